// File: rtl/csa_accum_pkg.sv
// Shared types and default widths for the carry-save accumulator sequencer.
package csa_accum_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_ACC_W = 8;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/csa_row.sv
// Combinational 3:2 compressor; c_next is already shifted left by one, top carry dropped.
module csa_row #(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] x,
    input  logic [ACC_W-1:0] s,
    input  logic [ACC_W-1:0] c,
    output logic [ACC_W-1:0] s_next,
    output logic [ACC_W-1:0] c_next
);

    assign c_next[0] = 1'b0;

    for (genvar gi = 0; gi < ACC_W; gi++) begin : g_bit
        assign s_next[gi] = x[gi] ^ s[gi] ^ c[gi];
        if (gi < ACC_W - 1) begin : g_carry
            assign c_next[gi+1] = (x[gi] & s[gi]) | (x[gi] & c[gi]) | (s[gi] & c[gi]);
        end
    end

endmodule

// File: rtl/csa_accum_seq.sv
// Carry-save accumulation sequencer: IDLE -> ACCUM -> RESOLVE -> DONE.
// Define CSA_ACCUM_ITER_RESOLVE_EN to resolve the redundant pair iteratively instead of with one wide adder.
module csa_accum_seq
    import csa_accum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       num_ops,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             busy
);

    state_t             state_reg;
    logic [ACC_W-1:0]   sum_reg;
    logic [ACC_W-1:0]   carry_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   num_ops_reg;
    logic [ACC_W-1:0]   out_sum_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic               busy_reg;

    logic [ACC_W-1:0]   x_ext;
    logic [ACC_W-1:0]   sum_next;
    logic [ACC_W-1:0]   carry_next;
    logic [CNT_W-1:0]   cnt_next;

    assign x_ext    = ACC_W'(in_data);
    assign cnt_next = cnt_reg + CNT_W'(1);

    csa_row #(.ACC_W(ACC_W)) u_row (
        .x      (x_ext),
        .s      (sum_reg),
        .c      (carry_reg),
        .s_next (sum_next),
        .c_next (carry_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            sum_reg       <= '0;
            carry_reg     <= '0;
            cnt_reg       <= '0;
            num_ops_reg   <= '0;
            out_sum_reg   <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        num_ops_reg <= num_ops;
                        sum_reg     <= '0;
                        carry_reg   <= '0;
                        cnt_reg     <= '0;
                        busy_reg    <= 1'b1;
                        if (num_ops == '0) begin
                            out_sum_reg   <= '0;
                            out_valid_reg <= 1'b1;
                            state_reg     <= ST_DONE;
                        end else begin
                            in_ready_reg <= 1'b1;
                            state_reg    <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (in_valid && in_ready_reg) begin
                        sum_reg   <= sum_next;
                        carry_reg <= carry_next;
                        cnt_reg   <= cnt_next;
                        if (cnt_next == num_ops_reg) begin
                            in_ready_reg <= 1'b0;
                            state_reg    <= ST_RESOLVE;
                        end
                    end
                end
                ST_RESOLVE: begin
`ifdef CSA_ACCUM_ITER_RESOLVE_EN
                    // Half-adder ripple over the whole word per cycle until no carries remain.
                    if (carry_reg == '0) begin
                        out_sum_reg   <= sum_reg;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end else begin
                        sum_reg   <= sum_reg ^ carry_reg;
                        carry_reg <= (sum_reg & carry_reg) << 1;
                    end
`else
                    out_sum_reg   <= sum_reg + carry_reg;
                    out_valid_reg <= 1'b1;
                    state_reg     <= ST_DONE;
`endif
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    in_ready_reg  <= 1'b0;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_csa_accum_seq.sv
// Self-checking bench for csa_accum_seq: randomized runs against a plain-arithmetic sum model,
// results checked by a separate monitor popping an expected-result queue.
module tb_csa_accum_seq;

    localparam int WIDTH = 4;
    localparam int ACC_W = 8;
`ifdef CSA_ACCUM_ITER_RESOLVE_EN
    localparam int FIXED_LAT = -1;
    localparam int ONE_ONE_LAT = 3;
`else
    localparam int FIXED_LAT = 2;
    localparam int ONE_ONE_LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       num_ops = '0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_sum;
    logic             busy;

    int               total = 0;
    int               bad = 0;
    logic [ACC_W-1:0] exp_q[$];
    logic [ACC_W-1:0] mon_exp;
    logic [WIDTH-1:0] ops[16];

    always #5 clk = ~clk;

    csa_accum_seq #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_ops   (num_ops),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake consumes one expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL result_unexpected: got %0d required none", out_sum);
            end else begin
                mon_exp = exp_q.pop_front();
                $display("result out_sum=%0d expected=%0d", out_sum, mon_exp);
                check("result", out_sum, mon_exp);
            end
        end
    end

    task automatic run(input int n, input bit gaps, input int hold, input bit poke, input int want_lat);
        int unsigned acc;
        int idx;
        int cyc;
        int lat;
        bit take;
        acc = 0;
        idx = 0;
        cyc = 0;
        for (int i = 0; i < n; i++) acc += ops[i];
        exp_q.push_back(ACC_W'(acc));
        start   = 1'b1;
        num_ops = 4'(n);
        step();
        start   = 1'b0;
        num_ops = 4'($urandom);
        check("busy_after_start", busy, 1);
        check("in_ready_after_start", in_ready, (n != 0));
        while (in_ready && cyc < 200) begin
            in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_data  = ops[idx % 16];
            start    = poke && (cyc == 1);
            take     = in_valid;
            step();
            if (take) idx++;
            cyc++;
        end
        start    = 1'b0;
        in_valid = ($urandom_range(0, 1) == 1);
        in_data  = 4'($urandom);
        check("accept_count", idx, n);
        lat = 1;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        if (n == 0)
            check("zero_ops_latency", lat, 1);
        else if (want_lat > 0)
            check("resolve_latency", lat, want_lat);
        else
            check("resolve_latency_bound", (lat <= ACC_W + 2), 1);
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", out_valid, 1);
            check("hold_sum", out_sum, ACC_W'(acc));
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("idle_valid", out_valid, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held low with start asserted.
        rst_n    = 1'b0;
        start    = 1'b1;
        num_ops  = 4'd5;
        in_valid = 1'b1;
        repeat (2) begin
            step();
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_busy", busy, 0);
            check("rst_out_sum", out_sum, 0);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        check("post_rst_busy", busy, 0);

        ops[0] = 4'b1010;
        ops[1] = 4'b1011;
        run(2, 1'b0, 0, 1'b0, FIXED_LAT);

        for (int i = 0; i < 16; i++) ops[i] = 4'hF;
        run(15, 1'b1, 0, 1'b0, FIXED_LAT);

        run(0, 1'b0, 0, 1'b0, FIXED_LAT);

        ops[0] = 4'd1;
        ops[1] = 4'd1;
        run(2, 1'b0, 0, 1'b0, ONE_ONE_LAT);

        for (int i = 0; i < 16; i++) ops[i] = 4'($urandom);
        run(6, 1'b1, 5, 1'b1, FIXED_LAT);

        // Reset after 3 of 8 operands: no result may appear.
        start   = 1'b1;
        num_ops = 4'd8;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'd7;
        repeat (3) step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        step();
        check("midrst_still_idle", busy, 0);

        ops[0] = 4'b1111;
        ops[1] = 4'b1101;
        run(2, 1'b0, 1, 1'b0, FIXED_LAT);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 16; i++) ops[i] = 4'($urandom);
            run(int'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1),
                int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1), FIXED_LAT);
        end

        step();
        check("pending_results", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csa_accum_seq.md
# csa_accum_seq

Sequencer that owns one carry-save accumulator and sums a run of `WIDTH`-bit operands. Operands are accepted one per handshake and held in redundant (sum, carry) form, so no carry propagates during accumulation. After the last operand the block resolves the pair into a single binary result and presents it on an output handshake. It sits between an operand source and a consumer in the adder datapath family, reusing the 3:2 carry-save stage instead of a chain of carry-propagate adders.

## Interface
- `WIDTH`, 4, operand width in bits
- `ACC_W`, 8, accumulator/result width; must be ≥ `WIDTH` + 4 so 15 full-scale operands cannot overflow
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous and active-low
- `start`  in  1  begin a run; sampled only in IDLE
- `num_ops`  in  4  operand count for the run, latched on `start`; 0 to 15
- `in_valid`  in  1  operand present
- `in_data`  in  `WIDTH`  operand, zero-extended to `ACC_W`
- `in_ready`  out  1  block accepts an operand this cycle
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer takes the result
- `out_sum`  out  `ACC_W`  final sum, modulo 2^`ACC_W`
- `busy`  out  1  high in every state except IDLE

## Operation
- States: IDLE, ACCUM, RESOLVE, DONE.
- **IDLE**
  - On `start`, latch `num_ops` and clear `sum_r`, `carry_r` and the operand count.
  - `num_ops` = 0 → go to DONE with `out_sum` = 0.
  - Otherwise → go to ACCUM.
- **ACCUM**
  - `in_ready` = 1.
  - Each cycle with `in_valid & in_ready`:
    - `sum_r` ← `x ^ sum_r ^ carry_r`
    - `carry_r` ← `maj(x, sum_r, carry_r) << 1`, truncated to `ACC_W` (the bit shifted out is dropped)
  - When the accepted count reaches `num_ops` → go to RESOLVE.
- **RESOLVE**: reduces (`sum_r`, `carry_r`) to binary; see Configuration.
- **DONE**
  - `out_valid` = 1 and `out_sum` is stable.
  - On `out_valid & out_ready` → go to IDLE.
- `start` outside IDLE is ignored; it is neither queued nor an error.
- `in_valid` outside ACCUM is ignored and the operand is not consumed.
- `out_sum` holds its last value in IDLE until the next result is written.

## Timing
- Reset values: `in_ready` 0, `out_valid` 0, `out_sum` 0, `busy` 0, state IDLE, internal registers 0.
- `rst_n` low mid-run: the partial run is discarded and the block is in IDLE on the next edge. No result is emitted.
- `start` at edge k:
  - `busy` = 1 and `in_ready` = 1 from cycle k+1.
  - An operand can be accepted every cycle; there are no bubbles.
- Last operand accepted at edge m → RESOLVE from cycle m+1.
- `num_ops` = 0: `start` at edge k → `out_valid` = 1 at cycle k+1.
- `out_valid` stays high until accepted.
- `out_ready` high in the first DONE cycle → IDLE on the next edge. A new `start` is then accepted one cycle later; there is no same-cycle DONE→ACCUM path.

## Configuration
- Macro: `CSA_ACCUM_ITER_RESOLVE_EN`.
- **Not defined**
  - RESOLVE lasts exactly 1 cycle: `out_sum` ← `sum_r + carry_r` using a full `ACC_W` carry-propagate adder, then go to DONE.
  - Total latency from last operand to `out_valid` = 2 cycles.
- **Defined**
  - Iterative resolution, no wide adder. Each RESOLVE cycle:
    - If `carry_r` == 0: `out_sum` ← `sum_r`, go to DONE.
    - Else: `sum_r` ← `sum_r ^ carry_r` and `carry_r` ← `(sum_r & carry_r) << 1`, truncated.
  - RESOLVE lasts (steps + 1) cycles, where steps is between 0 and `ACC_W`.
- `out_sum` is identical in both builds.

## Structure
- Package `csa_accum_pkg` holds:
  - the state enum
  - the default widths
  - `CNT_W` = 4
- Sub-module `csa_row`: combinational 3:2 compressor of width `ACC_W` (inputs x, s, c; outputs s_next, c_next already shifted). Instantiated once and used in ACCUM only.

## Test plan
- Reset: drive `rst_n` = 0 for 2 cycles with `start` = 1 → all outputs 0, stays in IDLE.
- Two operands, `num_ops` = 2, inputs 4'b1010 and 4'b1011 back-to-back → `out_sum` = 21. With the macro undefined, `out_valid` appears exactly 2 cycles after the second accept.
- Full scale: `num_ops` = 15, all inputs 4'hF, with `in_valid` randomly gapped → `out_sum` = 225 and exactly 15 accepts.
- `num_ops` = 0 → `out_valid` at k+1 with `out_sum` = 0, and `in_ready` never asserts.
- Macro defined, operands 1 and 1 → RESOLVE takes 2 cycles and `out_sum` = 2.
- Mixed control events:
  - Hold `out_ready` = 0 for 5 cycles → `out_valid` and `out_sum` stay stable.
  - `start` pulsed during ACCUM → ignored.
  - `rst_n` low after 3 of 8 operands → IDLE. A fresh run of 4'b1111 + 4'b1101 then gives 28.
